noc_pkt_reassembler: RTL and testbench
======================================

Name: noc_pkt_reassembler

Overview:
- Receive-side end of the flit protocol, in the AXI clock domain, directly downstream of the NoC-to-AXI clock-domain-crossing FIFO read port.
- Accepts head/body/tail flits, checks the header against the flits that follow, and buffers the payload of one packet.
- Replays the packet as a beat stream (valid/ready/last) with source coordinates and length for the AXI read-data logic.
- Malformed or orphan flits are dropped and counted, never forwarded as data.

Parameters:
- FLIT_DATA_WIDTH, 32, payload bits per flit (excludes the 2-bit flit type).
- MAX_PKT_FLITS, 16, buffer depth; largest legal pkt_size.
- X_WIDTH, 2, width of the source X coordinate field.
- Y_WIDTH, 2, width of the source Y coordinate field.
- PKT_SIZE_WIDTH, 8, width of the pkt_size header field.

Ports:
- clk_axi  in  1  AXI domain clock.
- arst_axi  in  1  asynchronous reset, active-low.
- in_valid  in  1  flit valid (CDC FIFO not empty).
- in_type  in  2  flit type: HEAD=0, BODY=1, TAIL=2, HEAD_TAIL=3.
- in_data  in  FLIT_DATA_WIDTH  flit payload.
- in_ready  out  1  flit accepted when in_valid && in_ready.
- out_valid  out  1  payload beat valid.
- out_data  out  FLIT_DATA_WIDTH  payload beat.
- out_last  out  1  final beat of the packet.
- out_src_x  out  X_WIDTH  source X coordinate; stable for the whole packet.
- out_src_y  out  Y_WIDTH  source Y coordinate; stable for the whole packet.
- out_len  out  PKT_SIZE_WIDTH  number of beats in the packet; stable for the whole packet.
- out_err  out  1  packet closed abnormally; stable for the whole packet.
- out_ready  in  1  downstream accepts a beat.
- drop_cnt  out  8  count of discarded flits; saturates at 255.

Behaviour:
- Head flit layout:
  - pkt_size = in_data[FW-1 -: PKT_SIZE_WIDTH]
  - src_x = next X_WIDTH bits below pkt_size
  - src_y = next Y_WIDTH bits below src_x
  - remaining low bits are ignored
- Reset (arst_axi low, asynchronous) clears the following immediately, with no clock edge required:
  - state=IDLE, all pointers and counters, drop_cnt=0
  - in_ready=0, out_valid=0, out_last=0, out_err=0
  - out_data, out_len, out_src_x, out_src_y=0
- in_ready=1 in IDLE and FILL, 0 in SEND. Accepting a flit never depends on out_ready.
- IDLE:
  - Accepted HEAD with 1<=pkt_size<=MAX_PKT_FLITS: latch src_x/src_y/len, wr_ptr=0, err=0, go to FILL.
  - HEAD with pkt_size=0 or >MAX_PKT_FLITS: drop_cnt+1, stay IDLE.
  - HEAD_TAIL: drop_cnt+1, stay IDLE.
  - BODY or TAIL (orphan): drop_cnt+1, stay IDLE.
- FILL (one flit per cycle):
  - BODY/TAIL: buf[wr_ptr]=in_data, wr_ptr+1.
  - TAIL with wr_ptr+1 < len: early close; err=1, len=wr_ptr+1, go to SEND.
  - Flit with wr_ptr+1 == len: go to SEND; err=1 unless its type is TAIL.
  - HEAD or HEAD_TAIL during FILL: flit is NOT written to the buffer; drop_cnt+1; err=1; len=wr_ptr. If wr_ptr==0, discard the packet and return to IDLE; otherwise go to SEND.
- SEND:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1).
  - Beat transfers when out_ready=1; rd_ptr advances.
  - Last beat accepted: rd_ptr=0, go to IDLE; in_ready=1 from the next cycle.
  - out_valid with out_data/out_last/out_len/out_src_x/out_src_y/out_err must hold stable while out_ready=0.
- Latency: the first beat is valid the cycle after the closing flit is accepted. A packet of N flits occupies N+1 input cycles and at least N output cycles.
- Throughput: no overlap of FILL and SEND; one packet in flight at a time.
- drop_cnt saturates at 255 and never wraps.
- Buffer is flops, not RAM; read is combinational from rd_ptr.
- Reset asserted mid-packet abandons the packet. No partial output after reset.

Decomposition:
- Shared package (ravenoc_pkg): flit_type_t enum (HEAD/BODY/TAIL/HEAD_TAIL) and s_rx_hdr_t {pkt_size, src_x, src_y} with a header-extract function; also used by the packet generator.
- State enum {IDLE, FILL, SEND} is local to the module.
- No sub-module; the buffer is an inline flop array.

Test Plan:
- Nominal packet: HEAD(size=3, src=(1,2)) then BODY 0xA, BODY 0xB, TAIL 0xC, out_ready=1 -> beats A,B,C; out_last only on C; out_len=3; out_src=(1,2); out_err=0; first beat the cycle after TAIL.
- Backpressure: same packet, out_ready toggled 1010 -> every beat held stable while stalled; in_ready=0 throughout SEND; a HEAD offered during SEND is stalled, not lost.
- Early tail: HEAD(size=4), BODY 0x1, TAIL 0x2 -> two beats 1,2; out_len=2; out_err=1; drop_cnt unchanged.
- Orphan and bad heads: TAIL, BODY, HEAD(size=0), HEAD(size=17), HEAD_TAIL -> no output; drop_cnt=5; in_ready stays 1.
- Head during FILL: HEAD(size=3), BODY 0x7, HEAD(size=1) -> one beat 0x7 with out_err=1; drop_cnt+1; second head not captured. Separately, 300 orphan flits -> drop_cnt=255.
- Reset mid-SEND: assert arst_axi after the first beat of a 4-beat packet -> out_valid=0 asynchronously; after release, a new HEAD(size=1)/TAIL 0x9 yields a single beat 0x9 with out_err=0.

Source files
------------

// File: rtl/ravenoc_pkg.sv
// Flit encoding and receive-header helpers shared by the packet reassembler and the packet generator.
package ravenoc_pkg;

  localparam int RX_DATA_W = 32;
  localparam int RX_SIZE_W = 8;
  localparam int RX_X_W    = 2;
  localparam int RX_Y_W    = 2;

  typedef enum logic [1:0] {
    HEAD      = 2'd0,
    BODY      = 2'd1,
    TAIL      = 2'd2,
    HEAD_TAIL = 2'd3
  } flit_type_t;

  typedef struct packed {
    logic [RX_SIZE_W-1:0] pkt_size;
    logic [RX_X_W-1:0]    src_x;
    logic [RX_Y_W-1:0]    src_y;
  } s_rx_hdr_t;

  // Header fields sit at the top of the flit payload; the low bits are unused.
  function automatic s_rx_hdr_t get_rx_hdr(input logic [RX_DATA_W-1:0] data);
    s_rx_hdr_t h;
    h = data[RX_DATA_W-1 -: $bits(s_rx_hdr_t)];
    return h;
  endfunction

endpackage

// File: rtl/noc_pkt_reassembler.sv
// Receive-side flit reassembler: checks head/body/tail framing, buffers one packet in flops
// and replays it as a valid/ready beat stream; malformed or orphan flits are dropped and counted.
//
// state | meaning
// IDLE  | waiting for a legal HEAD; everything else is dropped
// FILL  | writing BODY/TAIL payload into the buffer
// SEND  | replaying buffered beats downstream; input stalled
module noc_pkt_reassembler #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int MAX_PKT_FLITS   = 16,
  parameter int X_WIDTH         = 2,
  parameter int Y_WIDTH         = 2,
  parameter int PKT_SIZE_WIDTH  = 8
) (
  input  logic                       clk_axi,
  input  logic                       arst_axi,
  input  logic                       in_valid,
  input  logic [1:0]                 in_type,
  input  logic [FLIT_DATA_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [FLIT_DATA_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic [X_WIDTH-1:0]         out_src_x,
  output logic [Y_WIDTH-1:0]         out_src_y,
  output logic [PKT_SIZE_WIDTH-1:0]  out_len,
  output logic                       out_err,
  input  logic                       out_ready,
  output logic [7:0]                 drop_cnt
);
  import ravenoc_pkg::*;

  localparam int FW    = FLIT_DATA_WIDTH;
  localparam int SW    = PKT_SIZE_WIDTH;
  localparam int IDX_W = (MAX_PKT_FLITS > 1) ? $clog2(MAX_PKT_FLITS) : 1;
  localparam int PTR_W = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]      len_q, len_d;
  logic [X_WIDTH-1:0] src_x_q, src_x_d;
  logic [Y_WIDTH-1:0] src_y_q, src_y_d;
  logic               err_q, err_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               rdy_en_q;
  logic [FW-1:0]      buf_q [MAX_PKT_FLITS];

  flit_type_t         ftype;
  logic [SW-1:0]      hdr_size;
  logic [X_WIDTH-1:0] hdr_x;
  logic [Y_WIDTH-1:0] hdr_y;
  logic               hdr_ok;
  logic               accept;
  logic               buf_we;
  logic               drop_evt;
  logic [SW-1:0]      wr_inc;

  assign ftype    = flit_type_t'(in_type);
  assign hdr_size = in_data[FW-1 -: SW];
  assign hdr_x    = in_data[FW-1-SW -: X_WIDTH];
  assign hdr_y    = in_data[FW-1-SW-X_WIDTH -: Y_WIDTH];
  assign hdr_ok   = (hdr_size != '0) && (hdr_size <= SW'(MAX_PKT_FLITS));
  assign wr_inc   = SW'(wr_ptr_q) + SW'(1);

  // rdy_en_q keeps in_ready low while reset is held and for the first edge after release.
  assign in_ready  = rdy_en_q && (state_q != SEND);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? buf_q[rd_ptr_q[IDX_W-1:0]] : '0;
  assign out_last  = out_valid && (SW'(rd_ptr_q) == len_q - SW'(1));
  assign out_len   = len_q;
  assign out_src_x = src_x_q;
  assign out_src_y = src_y_q;
  assign out_err   = err_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    src_x_d  = src_x_q;
    src_y_d  = src_y_q;
    err_d    = err_q;
    buf_we   = 1'b0;
    drop_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ftype == HEAD && hdr_ok) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            len_d    = hdr_size;
            src_x_d  = hdr_x;
            src_y_d  = hdr_y;
            err_d    = 1'b0;
          end else begin
            drop_evt = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (ftype == HEAD || ftype == HEAD_TAIL) begin
            // An intruding header truncates the packet to what was already buffered.
            drop_evt = 1'b1;
            err_d    = 1'b1;
            len_d    = SW'(wr_ptr_q);
            state_d  = (wr_ptr_q == '0) ? IDLE : SEND;
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (wr_inc == len_q) begin
              state_d = SEND;
              err_d   = (ftype != TAIL);
            end else if (ftype == TAIL) begin
              state_d = SEND;
              err_d   = 1'b1;
              len_d   = wr_inc;
            end
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_last) begin
            rd_ptr_d = '0;
            state_d  = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    drop_cnt_d = (drop_evt && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      src_x_q    <= '0;
      src_y_q    <= '0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk_axi or negedge arst_axi) begin
    if (!arst_axi) begin
      for (int i = 0; i < MAX_PKT_FLITS; i++) buf_q[i] <= '0;
    end else if (buf_we) begin
      buf_q[wr_ptr_q[IDX_W-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_noc_pkt_reassembler.sv
// Bench for noc_pkt_reassembler: flit vector table plus hand-written corner sequences, with
// expected beats queued from a packet-level reference model and popped as the DUT emits them.
module tb_noc_pkt_reassembler;
  import ravenoc_pkg::*;

  logic        clk_axi = 1'b0;
  logic        arst_axi;
  logic        in_valid;
  logic [1:0]  in_type;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [1:0]  out_src_x;
  logic [1:0]  out_src_y;
  logic [7:0]  out_len;
  logic        out_err;
  logic        out_ready;
  logic [7:0]  drop_cnt;

  noc_pkt_reassembler dut (
    .clk_axi(clk_axi), .arst_axi(arst_axi),
    .in_valid(in_valid), .in_type(in_type), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src_x(out_src_x), .out_src_y(out_src_y), .out_len(out_len), .out_err(out_err),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk_axi = ~clk_axi;

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic [7:0]  len;
    logic [1:0]  x;
    logic [1:0]  y;
    logic        err;
  } beat_t;

  typedef struct {
    flit_type_t  t;
    logic [31:0] d;
    logic        exp_rdy;
    logic [7:0]  exp_drop;
  } vec_t;

  beat_t       sb[$];
  vec_t        vt[22];
  int          n_checks = 0;
  int          n_fail   = 0;

  int          m_fill = 0;
  int          m_len  = 0;
  logic [1:0]  m_x, m_y;
  logic [31:0] m_buf[$];

  logic        prev_stall = 1'b0;
  logic [45:0] prev_snap  = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int sz, input int x, input int y);
    return {sz[7:0], x[1:0], y[1:0], 20'h0};
  endfunction

  task automatic emit(input int n, input logic err);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = m_buf[i]; b.last = (i == n - 1); b.len = 8'(n);
      b.x = m_x; b.y = m_y; b.err = err;
      sb.push_back(b);
    end
  endtask

  // Packet-level reference: what downstream should see for each accepted flit.
  task automatic model_flit(input flit_type_t t, input logic [31:0] d);
    int sz;
    sz = int'(d[31:24]);
    if (m_fill == 0) begin
      if (t == HEAD && sz >= 1 && sz <= 16) begin
        m_fill = 1; m_len = sz; m_x = d[23:22]; m_y = d[21:20]; m_buf.delete();
      end
    end else if (t == HEAD || t == HEAD_TAIL) begin
      if (m_buf.size() != 0) emit(m_buf.size(), 1'b1);
      m_fill = 0;
    end else begin
      m_buf.push_back(d);
      if (m_buf.size() == m_len) begin
        emit(m_len, t != TAIL);
        m_fill = 0;
      end else if (t == TAIL) begin
        emit(m_buf.size(), 1'b1);
        m_fill = 0;
      end
    end
  endtask

  task automatic send_flit(input flit_type_t t, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk_axi);
    in_valid = 1'b1; in_type = t; in_data = d;
    while (!in_ready && n < 200) begin
      @(negedge clk_axi);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge clk_axi);
      #1 in_valid = 1'b0;
      model_flit(t, d);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk_axi);
      n++;
    end
    if (n >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
    end
  endtask

  always @(negedge clk_axi) begin
    beat_t e;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_beat", 64'({out_data, out_last, out_len, out_src_x, out_src_y, out_err}),
          64'(prev_snap));
    end
    if (out_valid) chk("in_ready_in_send", 64'(in_ready), 64'd0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_beat: got data 0x%0h expected no beat", out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 64'(out_data), 64'(e.d));
        chk("beat_last", 64'(out_last), 64'(e.last));
        chk("beat_len",  64'(out_len),  64'(e.len));
        chk("beat_src",  64'({out_src_x, out_src_y}), 64'({e.x, e.y}));
        chk("beat_err",  64'(out_err),  64'(e.err));
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_snap  = {out_data, out_last, out_len, out_src_x, out_src_y, out_err};
  end

  initial begin
    vt[0]  = '{HEAD,      hdr(3, 1, 2),  1'b1, 8'd0};
    vt[1]  = '{BODY,      32'hA,         1'b1, 8'd0};
    vt[2]  = '{BODY,      32'hB,         1'b1, 8'd0};
    vt[3]  = '{TAIL,      32'hC,         1'b0, 8'd0};
    vt[4]  = '{HEAD,      hdr(4, 3, 1),  1'b1, 8'd0};
    vt[5]  = '{BODY,      32'h1,         1'b1, 8'd0};
    vt[6]  = '{TAIL,      32'h2,         1'b0, 8'd0};
    vt[7]  = '{TAIL,      32'h3,         1'b1, 8'd1};
    vt[8]  = '{BODY,      32'h4,         1'b1, 8'd2};
    vt[9]  = '{HEAD,      hdr(0, 1, 1),  1'b1, 8'd3};
    vt[10] = '{HEAD,      hdr(17, 1, 1), 1'b1, 8'd4};
    vt[11] = '{HEAD_TAIL, hdr(1, 1, 1),  1'b1, 8'd5};
    vt[12] = '{HEAD,      hdr(3, 2, 3),  1'b1, 8'd5};
    vt[13] = '{BODY,      32'h7,         1'b1, 8'd5};
    vt[14] = '{HEAD,      hdr(1, 0, 0),  1'b0, 8'd6};
    vt[15] = '{TAIL,      32'hEE,        1'b1, 8'd7};
    vt[16] = '{HEAD,      hdr(2, 1, 1),  1'b1, 8'd7};
    vt[17] = '{HEAD_TAIL, hdr(1, 2, 2),  1'b1, 8'd8};
    vt[18] = '{BODY,      32'h5,         1'b1, 8'd9};
    vt[19] = '{HEAD,      hdr(2, 0, 3),  1'b1, 8'd9};
    vt[20] = '{BODY,      32'h11,        1'b1, 8'd9};
    vt[21] = '{BODY,      32'h22,        1'b0, 8'd9};

    arst_axi = 1'b1; in_valid = 1'b0; in_type = 2'd0; in_data = '0; out_ready = 1'b1;
    #1 arst_axi = 1'b0;
    #2;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    chk("rst_fields",    64'({out_data, out_len, out_src_x, out_src_y}), 64'd0);
    chk("rst_drop",      64'(drop_cnt),  64'd0);
    repeat (3) @(posedge clk_axi);
    @(negedge clk_axi) arst_axi = 1'b1;
    repeat (2) @(posedge clk_axi);
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 22; i++) begin
      send_flit(vt[i].t, vt[i].d);
      chk($sformatf("vec%0d_drop", i),  64'(drop_cnt),  64'(vt[i].exp_drop));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'(vt[i].exp_rdy));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(!vt[i].exp_rdy));
    end
    wait_idle();

    // Backpressure 1010 on the beat stream while a new packet waits at the input.
    send_flit(HEAD, hdr(3, 1, 2));
    send_flit(BODY, 32'hA);
    send_flit(BODY, 32'hB);
    send_flit(TAIL, 32'hC);
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          out_ready = (i % 2 == 0);
          @(posedge clk_axi);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        send_flit(HEAD, hdr(1, 3, 3));
        send_flit(TAIL, 32'h55);
      end
    join
    wait_idle();
    chk("bp_drop", 64'(drop_cnt), 64'd9);

    // Largest legal packet.
    send_flit(HEAD, hdr(16, 3, 0));
    for (int i = 0; i < 15; i++) send_flit(BODY, 32'h100 + 32'(i));
    send_flit(TAIL, 32'h1FF);
    chk("max_valid", 64'(out_valid), 64'd1);
    wait_idle();
    chk("max_drop", 64'(drop_cnt), 64'd9);

    for (int i = 0; i < 300; i++) send_flit(BODY, 32'(i));
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    chk("sat_ready", 64'(in_ready), 64'd1);
    chk("sat_no_beats", 64'(sb.size()), 64'd0);

    // Reset asserted after the first beat of a four-beat packet.
    send_flit(HEAD, hdr(4, 1, 0));
    send_flit(BODY, 32'h100);
    send_flit(BODY, 32'h200);
    send_flit(BODY, 32'h300);
    send_flit(TAIL, 32'h400);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clk_axi);
    #2 arst_axi = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready),  64'd0);
    chk("midrst_drop",  64'(drop_cnt),  64'd0);
    chk("midrst_len",   64'(out_len),   64'd0);
    chk("midrst_pending", 64'(sb.size()), 64'd3);
    sb.delete();
    m_fill = 0;
    m_buf.delete();
    @(negedge clk_axi) arst_axi = 1'b1;
    repeat (2) @(posedge clk_axi);
    send_flit(HEAD, hdr(1, 2, 1));
    send_flit(TAIL, 32'h9);
    chk("after_rst_valid", 64'(out_valid), 64'd1);
    wait_idle();
    chk("after_rst_drop", 64'(drop_cnt), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
